// File: rtl/cr_bcond.sv
// ---------------------------------------------------------------------------
// cr_bcond -- Condition Register owner and branch-condition resolver.
//
// Holds the eight 4-bit CR fields ({LT,GT,EQ,SO}, field 0 = bits 31:28),
// tracks outstanding CR-field writes with one saturating pending counter per
// field, and resolves conditional branches (BO/BI/CTR) once the referenced
// field is stable. Results are presented through a valid/ready output
// register.
//
// Parameters:
//   PEND_W  width of each pending counter (max outstanding = 2^PEND_W-1)
//   REGSZ   width of CTR and branch target
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   pend_valid/field     an issued instruction will write this CR field
//   wr_valid/field/crf   CR field writeback {LT,GT,EQ,SO}
//   br_valid/ready       branch request handshake (ready = evaluated now)
//   br_bo, br_bi         BO (br_bo[4] = BO0) and BI (0 selects CR bit 31)
//   br_ctr, br_target    current CTR and computed target
//   res_valid/ready      result handshake
//   res_taken            branch taken
//   res_target           copy of br_target
//   res_ctr, res_ctr_wr  new CTR value and its write-back enable
//   cr_out               architectural CR
//   pend_err             sticky pending-counter overflow flag
//
// Optional feature: define CR_BYPASS_EN to forward a writeback that clears
// the last pending write of the referenced field straight into evaluation.
// ---------------------------------------------------------------------------
module cr_bcond #(
  parameter int unsigned PEND_W = 2,
  parameter int unsigned REGSZ  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pend_valid,
  input  logic [2:0]       pend_field,
  input  logic             wr_valid,
  input  logic [2:0]       wr_field,
  input  logic [3:0]       wr_crf,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [4:0]       br_bo,
  input  logic [4:0]       br_bi,
  input  logic [REGSZ-1:0] br_ctr,
  input  logic [REGSZ-1:0] br_target,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [REGSZ-1:0] res_target,
  output logic [REGSZ-1:0] res_ctr,
  output logic             res_ctr_wr,
  output logic [31:0]      cr_out,
  output logic             pend_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FULL
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // Architectural state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_crf [8];
  logic [PEND_W-1:0] r_pend [8];
  logic              r_pend_err;

  // Result register
  logic              r_res_taken;
  logic              r_res_ctr_wr;
  logic [REGSZ-1:0]  r_res_target;
  logic [REGSZ-1:0]  r_res_ctr;

  // Per-field request decode
  logic [7:0]        w_pend_inc;
  logic [7:0]        w_wr_hit;

  // Branch evaluation
  logic [2:0]        w_fld;
  logic [PEND_W-1:0] w_fld_cnt;
  logic              w_full;
  logic              w_bypass;
  logic              w_eval;
  logic              w_accept;
  logic              w_cr_bit;
  logic [REGSZ-1:0]  w_ctr_m1;
  logic              w_ctr_ok;
  logic              w_cond_ok;
  logic              w_taken;

  // BO4 is only a prediction hint and plays no part in resolution.
  logic              w_unused_hint;
  assign w_unused_hint = br_bo[0];

  // -------------------------------------------------------------------------
  // Field decode for pend / writeback requests
  // -------------------------------------------------------------------------
  always_comb begin
    w_pend_inc = '0;
    w_wr_hit   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_pend_inc[i] = pend_valid && (pend_field == 3'(i));
      w_wr_hit[i]   = wr_valid   && (wr_field   == 3'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Pending counters. A pend and a writeback on the same field in one cycle
  // cancel out regardless of the count; a writeback on a zero count is an
  // unpended write and leaves the count at zero. Overflow holds the count and
  // raises the sticky error.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_pend[i] <= '0;
      end
      r_pend_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (w_pend_inc[i] && !w_wr_hit[i]) begin
          if (r_pend[i] == PEND_MAX) begin
            r_pend_err <= 1'b1;
          end else begin
            r_pend[i] <= r_pend[i] + PEND_ONE;
          end
        end else if (w_wr_hit[i] && !w_pend_inc[i] && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - PEND_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // CR fields
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_crf[i] <= '0;
      end
    end else if (wr_valid) begin
      r_crf[wr_field] <= wr_crf;
    end
  end

  assign cr_out = {r_crf[0], r_crf[1], r_crf[2], r_crf[3],
                   r_crf[4], r_crf[5], r_crf[6], r_crf[7]};

  // -------------------------------------------------------------------------
  // Branch evaluation
  // -------------------------------------------------------------------------
  assign w_fld     = br_bi[4:2];
  assign w_fld_cnt = r_pend[w_fld];
  assign w_full    = (r_state == ST_FULL);

`ifdef CR_BYPASS_EN
  // The writeback retiring the last outstanding write of F can feed the
  // evaluation directly while no result is held.
  assign w_bypass = !w_full && wr_valid && (wr_field == w_fld) &&
                    (w_fld_cnt == PEND_ONE);
`else
  assign w_bypass = 1'b0;
`endif

  // Within a field, bit 0 of BI[1:0] is LT, which sits at wr_crf[3].
  always_comb begin
    w_cr_bit = r_crf[w_fld][2'd3 - br_bi[1:0]];
    if (w_bypass) begin
      w_cr_bit = wr_crf[2'd3 - br_bi[1:0]];
    end
  end

  assign w_ctr_m1  = br_ctr - REGSZ'(1);
  assign w_ctr_ok  = br_bo[2] | ((w_ctr_m1 != '0) ^ br_bo[1]);
  assign w_cond_ok = br_bo[4] | (w_cr_bit == br_bo[3]);
  assign w_taken   = w_ctr_ok & w_cond_ok;

  // BO0 set means the CR bit is irrelevant, so a pending field never stalls.
  assign w_eval   = br_valid && (br_bo[4] || (w_fld_cnt == '0) || w_bypass);
  assign w_accept = w_eval && (!w_full || res_ready);

  // Gated with reset so the handshake is quiet while reset is held.
  assign br_ready = w_accept && reset;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (br_valid) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (res_ready) begin
          w_state_nxt = w_accept ? ST_FULL : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Result register: loads only on acceptance, so it is stable while held.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_taken  <= 1'b0;
      r_res_ctr_wr <= 1'b0;
      r_res_target <= '0;
      r_res_ctr    <= '0;
    end else if (w_accept) begin
      r_res_taken  <= w_taken;
      r_res_ctr_wr <= !br_bo[2];
      r_res_target <= br_target;
      r_res_ctr    <= br_bo[2] ? br_ctr : w_ctr_m1;
    end
  end

  assign res_valid  = w_full;
  assign res_taken  = r_res_taken;
  assign res_ctr_wr = r_res_ctr_wr;
  assign res_target = r_res_target;
  assign res_ctr    = r_res_ctr;
  assign pend_err   = r_pend_err;

endmodule

// File: tb/tb_cr_bcond.sv
module tb_cr_bcond;

`ifdef CR_BYPASS_EN
  localparam int ACC_LAT = 0;
  localparam bit BYP     = 1'b1;
`else
  localparam int ACC_LAT = 1;
  localparam bit BYP     = 1'b0;
`endif
  localparam int PMAX = 3;

  logic        clk;
  logic        reset;
  logic        pend_valid;
  logic [2:0]  pend_field;
  logic        wr_valid;
  logic [2:0]  wr_field;
  logic [3:0]  wr_crf;
  logic        br_valid;
  logic        br_ready;
  logic [4:0]  br_bo;
  logic [4:0]  br_bi;
  logic [31:0] br_ctr;
  logic [31:0] br_target;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] res_ctr;
  logic        res_ctr_wr;
  logic [31:0] cr_out;
  logic        pend_err;

  cr_bcond #(.PEND_W(2), .REGSZ(32)) dut (
    .clk(clk), .reset(reset),
    .pend_valid(pend_valid), .pend_field(pend_field),
    .wr_valid(wr_valid), .wr_field(wr_field), .wr_crf(wr_crf),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_bo(br_bo), .br_bi(br_bi), .br_ctr(br_ctr), .br_target(br_target),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_target(res_target),
    .res_ctr(res_ctr), .res_ctr_wr(res_ctr_wr),
    .cr_out(cr_out), .pend_err(pend_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    pend_valid = 0; pend_field = 0;
    wr_valid = 0; wr_field = 0; wr_crf = 0;
    br_valid = 0; br_bo = 0; br_bi = 0; br_ctr = 0; br_target = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    quiet();
    res_ready = 1;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic br(input logic [4:0] bo, input logic [4:0] bi,
                    input logic [31:0] ctr, input logic [31:0] tgt);
    br_valid = 1; br_bo = bo; br_bi = bi; br_ctr = ctr; br_target = tgt;
  endtask

  // Called at a negedge with the request already driven. Returns the number
  // of cycles until br_ready (-1 on timeout), positioned at the negedge after
  // acceptance with the request and side-band strobes dropped.
  task automatic wait_ready(input int max, output int n);
    n = -1;
    for (int c = 0; c < max; c++) begin
      #1;
      if (br_ready === 1'b1) begin
        n = c;
        @(negedge clk);
        br_valid = 0; wr_valid = 0; pend_valid = 0;
        return;
      end
      @(negedge clk);
      wr_valid = 0; pend_valid = 0;
    end
    br_valid = 0;
  endtask

  typedef struct {
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [31:0] ctr;
    logic [3:0]  crf;
    logic        taken;
    logic [31:0] rctr;
    logic        ctrwr;
  } vec_t;

  vec_t vec [14];

  // Reference model state
  logic [3:0]  m_cr [8];
  int          m_pend [8];
  bit          m_err, m_rv, m_taken, m_ctrwr;
  logic [31:0] m_tgt, m_ctr;

  function automatic logic [31:0] model_cr();
    logic [31:0] v;
    for (int g = 0; g < 8; g++) v[31-4*g -: 4] = m_cr[g];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hold;
    reset = 0;
    quiet();
    res_ready = 1;

    vec[0]  = '{5'b10100, 5'd0,  32'd5,          4'b0000, 1'b1, 32'd5,          1'b0};
    vec[1]  = '{5'b10000, 5'd0,  32'd1,          4'b0000, 1'b0, 32'd0,          1'b1};
    vec[2]  = '{5'b10000, 5'd0,  32'd0,          4'b0000, 1'b1, 32'hFFFF_FFFF,  1'b1};
    vec[3]  = '{5'b01100, 5'd2,  32'd7,          4'b0010, 1'b1, 32'd7,          1'b0};
    vec[4]  = '{5'b00100, 5'd2,  32'd7,          4'b0010, 1'b0, 32'd7,          1'b0};
    vec[5]  = '{5'b01100, 5'd12, 32'd3,          4'b1000, 1'b1, 32'd3,          1'b0};
    vec[6]  = '{5'b01100, 5'd31, 32'd3,          4'b0001, 1'b1, 32'd3,          1'b0};
    vec[7]  = '{5'b00100, 5'd31, 32'd3,          4'b0001, 1'b0, 32'd3,          1'b0};
    vec[8]  = '{5'b00010, 5'd5,  32'd1,          4'b0000, 1'b1, 32'd0,          1'b1};
    vec[9]  = '{5'b00010, 5'd5,  32'd2,          4'b0000, 1'b0, 32'd1,          1'b1};
    vec[10] = '{5'b10101, 5'd0,  32'd9,          4'b0000, 1'b1, 32'd9,          1'b0};
    vec[11] = '{5'b01000, 5'd22, 32'd3,          4'b0010, 1'b1, 32'd2,          1'b1};
    vec[12] = '{5'b01100, 5'd13, 32'd3,          4'b1000, 1'b0, 32'd3,          1'b0};
    vec[13] = '{5'b00000, 5'd0,  32'h8000_0000,  4'b0000, 1'b1, 32'h7FFF_FFFF,  1'b1};

    // ---- reset values
    do_reset();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_taken", res_taken, 0);
    chk("rst_res_ctr", res_ctr, 0);
    chk("rst_res_ctr_wr", res_ctr_wr, 0);
    chk("rst_res_target", res_target, 0);
    chk("rst_cr_out", cr_out, 0);
    chk("rst_pend_err", pend_err, 0);
    chk("rst_br_ready", br_ready, 0);

    // ---- table: unpended CR write, then an immediately evaluable branch
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_valid = 1; wr_field = vec[i].bi[4:2]; wr_crf = vec[i].crf;
      br_valid = 0; res_ready = 1;
      @(negedge clk);
      wr_valid = 0;
      br(vec[i].bo, vec[i].bi, vec[i].ctr, 32'h100 + 32'(4*i));
      #1 chk("tbl_br_ready", br_ready, 1);
      @(negedge clk);
      br_valid = 0;
      #1;
      chk("tbl_res_valid", res_valid, 1);
      chk("tbl_res_taken", res_taken, vec[i].taken);
      chk("tbl_res_ctr", res_ctr, vec[i].rctr);
      chk("tbl_res_ctr_wr", res_ctr_wr, vec[i].ctrwr);
      chk("tbl_res_target", res_target, 32'h100 + 32'(4*i));
    end

    // ---- interlock on CR0 with beq
    @(negedge clk);
    pend_valid = 1; pend_field = 0;
    @(negedge clk);
    pend_valid = 0;
    br(5'b01100, 5'd2, 32'd0, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      #1 chk("ilk_stall", br_ready, 0);
      @(negedge clk);
    end
    wr_valid = 1; wr_field = 0; wr_crf = 4'b0010;
    wait_ready(8, n);
    chk("ilk_accept_lat", 64'(n), 64'(ACC_LAT));
    #1;
    chk("ilk_res_valid", res_valid, 1);
    chk("ilk_res_taken", res_taken, 1);
    chk("ilk_res_target", res_target, 32'h2000);

    // ---- same-cycle pend+wr on field 3 leaves the count at 1
    @(negedge clk);
    pend_valid = 1; pend_field = 3;
    @(negedge clk);
    pend_valid = 1; pend_field = 3; wr_valid = 1; wr_field = 3; wr_crf = 4'b1000;
    @(negedge clk);
    pend_valid = 0; wr_valid = 0;
    br(5'b01100, 5'd12, 32'd0, 32'h3000);
    #1 chk("cnt_same_cycle_stall", br_ready, 0);
    @(negedge clk);
    wr_valid = 1; wr_field = 3; wr_crf = 4'b1000;
    wait_ready(8, n);
    chk("cnt_same_cycle_lat", 64'(n), 64'(ACC_LAT));
    #1 chk("cnt_same_cycle_taken", res_taken, 1);

    // ---- overflow on field 5
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pend_valid = 1; pend_field = 5;
    end
    @(negedge clk);
    pend_valid = 0;
    #1 chk("ovf_err_at_max", pend_err, 0);
    @(negedge clk);
    pend_valid = 1; pend_field = 5;
    @(negedge clk);
    pend_valid = 0;
    #1 chk("ovf_err_set", pend_err, 1);
    @(negedge clk);
    br(5'b01100, 5'd22, 32'd0, 32'h5000);
    #1 chk("ovf_stall_3", br_ready, 0);
    @(negedge clk);
    wr_valid = 1; wr_field = 5; wr_crf = 4'b0010;
    #1 chk("ovf_stall_w1", br_ready, 0);
    @(negedge clk);
    #1 chk("ovf_stall_w2", br_ready, 0);
    @(negedge clk);
    wait_ready(8, n);
    chk("ovf_accept_lat", 64'(n), 64'(ACC_LAT));
    #1;
    chk("ovf_res_taken", res_taken, 1);
    chk("ovf_err_sticky", pend_err, 1);

    // ---- backpressure
    @(negedge clk);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    br(5'b10100, 5'd0, 32'd4, 32'hA000);
    #1 chk("bp_first_ready", br_ready, 1);
    @(negedge clk);
    br(5'b10000, 5'd0, 32'd0, 32'hB000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_br_ready", br_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_target", res_target, 32'hA000);
      chk("bp_res_ctr", res_ctr, 32'd4);
      chk("bp_res_taken", res_taken, 1);
      @(negedge clk);
    end
    res_ready = 1;
    #1 chk("bp_release_ready", br_ready, 1);
    @(negedge clk);
    br_valid = 0;
    #1;
    chk("bp_second_valid", res_valid, 1);
    chk("bp_second_target", res_target, 32'hB000);
    chk("bp_second_ctr", res_ctr, 32'hFFFF_FFFF);
    chk("bp_second_ctr_wr", res_ctr_wr, 1);

    // ---- async reset while a branch waits and a result is held
    @(negedge clk);
    res_ready = 0;
    wr_valid = 1; wr_field = 1; wr_crf = 4'b1111;
    @(negedge clk);
    wr_valid = 0;
    br(5'b10100, 5'd0, 32'd9, 32'hDEAD_0000);
    #1 chk("ar_hold_ready", br_ready, 1);
    @(negedge clk);
    br_valid = 0;
    pend_valid = 1; pend_field = 2;
    @(negedge clk);
    pend_valid = 0;
    br(5'b01100, 5'd8, 32'd0, 32'h4000);
    #1;
    chk("ar_wait_stall", br_ready, 0);
    chk("ar_pre_cr1", cr_out[27:24], 4'hF);
    chk("ar_pre_valid", res_valid, 1);
    #2 reset = 0;
    #1;
    chk("ar_res_valid", res_valid, 0);
    chk("ar_res_taken", res_taken, 0);
    chk("ar_res_ctr", res_ctr, 0);
    chk("ar_res_ctr_wr", res_ctr_wr, 0);
    chk("ar_res_target", res_target, 0);
    chk("ar_cr_out", cr_out, 0);
    chk("ar_pend_err", pend_err, 0);
    chk("ar_br_ready", br_ready, 0);
    @(negedge clk);
    reset = 1;
    res_ready = 1;
    #1 chk("ar_pend_lost", br_ready, 1);
    @(negedge clk);
    br_valid = 0;
    #1;
    chk("ar_post_valid", res_valid, 1);
    chk("ar_post_taken", res_taken, 0);
    chk("ar_post_target", res_target, 32'h4000);

    // ---- randomized run against the reference model
    do_reset();
    for (int g = 0; g < 8; g++) begin m_cr[g] = 0; m_pend[g] = 0; end
    m_err = 0; m_rv = 0; m_taken = 0; m_ctrwr = 0; m_tgt = 0; m_ctr = 0;
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int f;
      bit byp, ev, exp_ready, crbit, ctr_ok, cond_ok;
      logic [31:0] crv, view, ctr_m1;
      @(negedge clk);
      if (!hold) begin
        br_valid = 1'($urandom_range(0, 1));
        br_bo = 5'($urandom);
        br_bi = 5'($urandom);
        case ($urandom_range(0, 3))
          0: br_ctr = 32'd0;
          1: br_ctr = 32'd1;
          2: br_ctr = 32'd2;
          default: br_ctr = $urandom;
        endcase
        br_target = $urandom;
      end
      pend_valid = ($urandom_range(0, 5) == 0);
      pend_field = 3'($urandom);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_field = 3'($urandom);
      wr_crf = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      crv = model_cr();
      chk("rnd_res_valid", res_valid, m_rv);
      if (m_rv) begin
        chk("rnd_res_taken", res_taken, m_taken);
        chk("rnd_res_target", res_target, m_tgt);
        chk("rnd_res_ctr", res_ctr, m_ctr);
        chk("rnd_res_ctr_wr", res_ctr_wr, m_ctrwr);
      end
      chk("rnd_cr_out", cr_out, crv);
      chk("rnd_pend_err", pend_err, m_err);

      f = int'(br_bi[4:2]);
      byp = 0;
`ifdef CR_BYPASS_EN
      byp = !m_rv && (m_pend[f] == 1) && wr_valid && (int'(wr_field) == f);
`endif
      ev = br_valid && (br_bo[4] || (m_pend[f] == 0) || byp);
      exp_ready = ev && (!m_rv || res_ready);
      chk("rnd_br_ready", br_ready, exp_ready);

      view = crv;
      if (byp) view[31-4*f -: 4] = wr_crf;
      crbit = view[31 - int'(br_bi)];
      ctr_m1 = br_ctr - 32'd1;
      ctr_ok = br_bo[2] || ((ctr_m1 != 0) != br_bo[1]);
      cond_ok = br_bo[4] || (crbit == br_bo[3]);

      if (exp_ready) begin
        m_rv = 1;
        m_taken = ctr_ok && cond_ok;
        m_tgt = br_target;
        m_ctr = br_bo[2] ? br_ctr : ctr_m1;
        m_ctrwr = !br_bo[2];
      end else if (m_rv && res_ready) begin
        m_rv = 0;
      end
      for (int g = 0; g < 8; g++) begin
        bit inc, hit;
        inc = pend_valid && (int'(pend_field) == g);
        hit = wr_valid && (int'(wr_field) == g);
        if (inc && !hit) begin
          if (m_pend[g] == PMAX) m_err = 1;
          else m_pend[g]++;
        end else if (hit && !inc && m_pend[g] > 0) begin
          m_pend[g]--;
        end
      end
      if (wr_valid) m_cr[wr_field] = wr_crf;
      hold = br_valid && !exp_ready;
    end

    @(negedge clk);
    quiet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_bcond.md
# cr_bcond

Condition Register owner and branch-condition resolver for the execute stage. It holds the eight 4-bit CR fields and accepts field writebacks from the integer flag generator, in {LT,GT,EQ,SO} order. It also tracks outstanding CR-field writes with per-field pending counters. Conditional branches are resolved against CR and CTR only once the referenced field is stable, and the result is presented through a valid/ready output register.

## Interface
Parameters:
- `PEND_W`, default 2: width of each per-field pending counter; max outstanding writes per field = 2^PEND_W−1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `pend_valid` in 1: an issued instruction will write CR field `pend_field`.
- `pend_field` in 3: field index (0 = CR0 = bits 31:28).
- `wr_valid` in 1: CR field writeback.
- `wr_field` in 3: field written.
- `wr_crf` in 4: {LT,GT,EQ,SO}.
- `br_valid` in 1: branch request.
- `br_ready` out 1: request accepted this cycle when high with `br_valid`.
- `br_bo` in 5: BO; `br_bo[4]` = BO0.
- `br_bi` in 5: BI; 0 selects CR bit 31.
- `br_ctr` in `REGSZ`: current CTR.
- `br_target` in `REGSZ`: computed target address.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer takes result.
- `res_taken` out 1: branch taken.
- `res_target` out `REGSZ`: copy of `br_target`.
- `res_ctr` out `REGSZ`: new CTR value.
- `res_ctr_wr` out 1: CTR must be written back.
- `cr_out` out 32: architectural CR.
- `pend_err` out 1: sticky, set on pending-counter overflow.

## Operation
Pending counters, one per field, each `PEND_W` bits:
- `pend_valid` increments the counter for `pend_field`.
- `wr_valid` with a nonzero count decrements the counter for `wr_field`.
- `pend_valid` and `wr_valid` on the same field in the same cycle leave the count unchanged.
- `wr_valid` with count 0 updates CR and the count stays 0. This is an unpended write (mtcrf/mcrf-style).
- `pend_valid` at the maximum count: the count holds and `pend_err` sets. Only reset clears `pend_err`.

CR update:
- `cr_out[31-4f -: 4] <= wr_crf` on `wr_valid`, where f = `wr_field`.

Branch evaluation:
- F = `br_bi[4:2]`.
- `ctr_m1` = `br_ctr` − 1, computed modulo 2^`REGSZ` (0 wraps to all-ones).
- `ctr_ok` = BO2 | ((`ctr_m1` != 0) ^ BO3).
- `cond_ok` = BO0 | (CR[BI] == BO1).
- `res_taken` = `ctr_ok` & `cond_ok`.
- `res_ctr` = BO2 ? `br_ctr` : `ctr_m1`.
- `res_ctr_wr` = !BO2.
- BO4 (the hint) is ignored.

State machine:
- IDLE
  - If `br_valid` and (BO0, or pending[F] == 0) and the output slot is free: evaluate, load the result register, go to FULL.
  - If `br_valid` and the field is pending: go to WAIT. The request must be held stable by the sender.
- WAIT
  - Leave when pending[F] reaches 0, or when the bypass condition holds. Then evaluate, go to FULL.
- FULL
  - `res_valid` = 1.
  - On `res_ready`: if a new request is immediately evaluable, reload and stay in FULL; else go to IDLE.

Handshake rules:
- `br_ready` is asserted only in the cycle the request is evaluated.
- `br_ready` = evaluable & (!`res_valid` | `res_ready`).
- `res_*` outputs stay stable while `res_valid` & !`res_ready`.

## Timing
Reset values: all CR fields 0, all pending counts 0, `pend_err` 0, `res_valid` 0, `res_taken` 0, `res_ctr` 0, `res_ctr_wr` 0, `res_target` 0, `br_ready` 0. State goes to IDLE.

Reset asserted mid-operation:
- Any waiting or held branch is discarded.
- The pending state is lost, so upstream must flush with it.

Latency:
- Unstalled branch: accepted in cycle N, `res_valid` in N+1.
- Writeback in cycle N: the CR is visible to evaluation in N+1, and its pending decrement also takes effect in N+1.
- Without bypass, a branch waiting on a count of 1 is accepted in the cycle after the clearing `wr_valid`.

Same-cycle write and evaluation:
- A `wr_valid` to a field not being waited on does not affect a branch evaluated in that cycle. The branch sees the pre-write CR.

## Configuration
Macro `CR_BYPASS_EN`:
- Defined: in IDLE or WAIT, if pending[F] == 1 and `wr_valid` targets F, the branch is evaluated in that same cycle using `wr_crf` for the bit. This saves one cycle.
- Undefined: no forwarding. Evaluation waits for the registered CR and the zero count.

## Test plan
- Unconditional, no pending: BO=10100, BI=0 → `res_valid` next cycle, `res_taken`=1, `res_ctr_wr`=0, `res_target`=`br_target`.
- bdnz wrap: BO=10000, CTR=1 → `res_ctr`=0, `res_taken`=0. With CTR=0 → `res_ctr`=0xFFFFFFFF, `res_taken`=1.
- Interlock: pend CR0, then issue beq (BO=01100, BI=2). Hold 3 cycles, then `wr_crf`=0010 on field 0 → `res_taken`=1. Acceptance occurs 1 cycle after the write without bypass, and in the same cycle with `CR_BYPASS_EN`.
- Counters: pend and wr on field 3 in the same cycle → count unchanged. Pend field 5 four times with `PEND_W`=2 → `pend_err`=1 and count=3.
- Backpressure: hold `res_ready`=0 for 4 cycles with a second `br_valid` presented → `br_ready`=0 and `res_*` stable. Raise `res_ready` → the second result loads the following cycle.
- Async reset mid-WAIT → all outputs return to reset values immediately, and `cr_out`=0.
